base3_digit_serializer: RTL and testbench
=========================================

// Module: base3_digit_serializer
// PURPOSE
//  Downstream consumer of the div_64_3 divide-by-3 core. Accepts a 64-bit word and emits its base-3
//  digits serially, LSB first, one digit per accepted output beat. Each beat takes R (digit) and
//  Q (next value) from one div_64_3 pass over the working register.
//  Sits between the registered divider datapath and radix-3 encoders / display logic.
// PARAMETERS
//  W       64  input word width; fixed at 64 to match div_64_3 (elaboration error otherwise)
//  MAXDIG  41  max digits for W bits (3^40 < 2^64-1 < 3^41)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous, active-low reset
//  in_x       in   64   word to convert
//  in_valid   in   1    in_x valid
//  in_ready   out  1    block can accept a word (high only in IDLE)
//  dig        out  2    current base-3 digit (0..2)
//  dig_idx    out  6    digit position, 0 = least significant
//  dig_last   out  1    this digit is the final one of the word
//  dig_valid  out  1    dig/dig_idx/dig_last valid
//  dig_ready  in   1    sink accepts current digit
// BEHAVIOUR
//  - States: IDLE, CONV. Reset -> IDLE, val_q=0, cnt_q=0. Outputs in reset: in_ready=1, dig_valid=0,
//    dig=0, dig_idx=0, dig_last=0.
//  - IDLE: in_ready=1. in_valid&in_ready -> val_q<=in_x, cnt_q<=0, CONV next cycle.
//  - CONV: in_ready=0, dig_valid=1; dig=R(val_q), dig_idx=cnt_q, dig_last as defined below;
//    dig/dig_last combinational from val_q via div_64_3, dig_valid from state register.
//  - Latency: first digit valid the cycle after input handshake.
//  - dig_last = (Q(val_q)==0), so in_x=0 yields a single digit 0.
//  - dig_valid&dig_ready & !dig_last: val_q<=Q(val_q), cnt_q<=cnt_q+1.
//  - dig_valid&dig_ready & dig_last: -> IDLE, cnt_q<=0. in_ready high next cycle.
//    Throughput: ndigits+1 cycles per word.
//  - Backpressure: dig_ready=0 holds val_q, cnt_q and all dig* outputs stable. dig_valid never drops
//    until handshake.
//  - in_valid in CONV ignored (in_ready=0); no input data is lost or latched.
//  - cnt_q never exceeds MAXDIG-1; dig_last is guaranteed at or before idx 40.
//  - rst_n low at any time (incl. mid-word): immediate abort, reset values above; no partial resume.
// CONFIGURATION
//  FIXED_LEN_EN defined: every word emits exactly MAXDIG (41) digits, zero-padded at the top.
//    dig_last = (cnt_q==MAXDIG-1); Q==0 does not terminate.
//  FIXED_LEN_EN undefined: variable length, terminates on Q==0 as above.
// STRUCTURE
//  - Package base3_pkg: MAXDIG=41, IDX_W=6, state encoding IDLE/CONV, DIG_W=2.
//  - One sub-module: existing div_64_3 (X=val_q -> Q[63:1], R[2:1]); Q zero-extended to 64 bits.
//  - No other hierarchy: FSM, val_q, cnt_q in this module.
// TESTING
//  1. in_x=0, dig_ready=1 -> one beat: dig=0, idx=0, last=1; in_ready=1 the following cycle.
//  2. in_x=5 -> beats (2,idx0,last0), (1,idx1,last1).
//  3. in_x=100, dig_ready toggling 1/0 -> digits 1,0,2,0,1 in order, held stable while stalled,
//     last on idx 4.
//  4. in_x=64'hFFFF_FFFF_FFFF_FFFF -> 41 digits, last at idx 40; sum(dig*3^idx) equals input.
//  5. in_x=100; rst_n low after 2nd digit -> dig_valid=0, in_ready=1 asynchronously.
//     Next word 5 converts cleanly as in test 2.
//  6. FIXED_LEN_EN, in_x=5 -> 2,1 then 39 zeros; last only at idx 40; in_valid during CONV ignored.

Source files
------------

// File: rtl/base3_pkg.sv
// Shared constants and state encoding for the base-3 digit serializer.
package base3_pkg;

  // 3^40 < 2^64-1 < 3^41, so a 64-bit word never needs more than 41 digits.
  localparam int unsigned MAXDIG = 41;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned DIG_W  = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

endpackage

// File: rtl/div_64_3.sv
// Combinational divide-by-3 of a 64-bit word: quotient (63 bits) and remainder (0..2).
module div_64_3 (
  input  logic [63:0] x_i,
  output logic [63:1] q_o,
  output logic [2:1]  r_o
);

  logic [2:0] cur;
  logic [1:0] rem;

  // Restoring long division, one bit per step. The quotient's top bit is always
  // zero (2^64 / 3 < 2^63), so the first step just seeds the remainder with x_i[63].
  always_comb begin
    q_o = '0;
    rem = {1'b0, x_i[63]};
    cur = '0;
    for (int i = 62; i >= 0; i--) begin
      cur = {rem, x_i[i]};
      if (cur >= 3'd3) begin
        cur        = cur - 3'd3;
        q_o[i + 1] = 1'b1;
      end
      rem = cur[1:0];
    end
    r_o = rem;
  end

endmodule

// File: rtl/base3_digit_serializer.sv
// Emits the base-3 digits of a 64-bit word, LSB first, one digit per output handshake.
// Build option FIXED_LEN_EN: always emit MAXDIG digits (zero-padded at the top)
// instead of stopping once the remaining value reaches zero.
module base3_digit_serializer
  import base3_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       in_x,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DIG_W-1:0]   dig,
  output logic [IDX_W-1:0]   dig_idx,
  output logic               dig_last,
  output logic               dig_valid,
  input  logic               dig_ready
);

  if (W != 64) begin : g_width_check
    $error("base3_digit_serializer: W must be 64 to match div_64_3");
  end

  state_e           state_q, state_d;
  logic [63:0]      val_q, val_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;

  logic [63:1]      div_q;
  logic [2:1]       div_r;
  logic [63:0]      quot;
  logic             last_raw;

  div_64_3 u_div (
    .x_i (val_q),
    .q_o (div_q),
    .r_o (div_r)
  );

  assign quot = {1'b0, div_q};

  // Output decode: digit fields are forced to zero outside CONV so idle outputs stay quiet.
  always_comb begin
`ifdef FIXED_LEN_EN
    last_raw  = (cnt_q == IDX_W'(MAXDIG - 1));
`else
    last_raw  = (quot == 64'd0);
`endif
    in_ready  = (state_q == IDLE);
    dig_valid = (state_q == CONV);
    dig       = dig_valid ? div_r : '0;
    dig_idx   = cnt_q;
    dig_last  = dig_valid & last_raw;
  end

  // Next-state: load on input handshake, shift by one digit on each output handshake.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          val_d   = in_x;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        if (dig_ready) begin
          if (last_raw) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            val_d = quot;
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
    endcase
  end

  // State registers with asynchronous abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      val_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_base3_digit_serializer.sv
// Scoreboard bench for base3_digit_serializer: expected beats are queued when a word
// is driven and popped as the DUT hands each digit over.
module tb_base3_digit_serializer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_x = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  dig;
  logic [5:0]  dig_idx;
  logic        dig_last;
  logic        dig_valid;
  logic        dig_ready = 1'b0;

  typedef struct packed {
    logic [1:0] dig;
    logic [5:0] idx;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  base3_digit_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_x      (in_x),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dig       (dig),
    .dig_idx   (dig_idx),
    .dig_last  (dig_last),
    .dig_valid (dig_valid),
    .dig_ready (dig_ready)
  );

  always #5 clk = ~clk;

  // Reference digit expansion by plain arithmetic.
  task automatic push_word(input logic [63:0] x);
    logic [63:0] v;
    int          idx;
    bit          done;
    beat_t       b;
    v    = x;
    idx  = 0;
    done = 1'b0;
    while (!done) begin
      b.dig = 2'(v % 64'd3);
      v     = v / 64'd3;
      b.idx = 6'(idx);
`ifdef FIXED_LEN_EN
      b.last = (idx == 40);
`else
      b.last = (v == 64'd0);
`endif
      exp_q.push_back(b);
      done = b.last;
      idx++;
    end
  endtask

  // Drive one word; stall=1 toggles dig_ready, poke=1 holds in_valid high with noise during CONV.
  task automatic run_word(input logic [63:0] x, input bit stall, input bit poke,
                          input logic [63:0] noise, output int nbeats,
                          output logic [127:0] recon);
    int          cyc;
    bit          fin;
    bit          rdy_t;
    bit          stalled;
    beat_t       held;
    beat_t       e;
    beat_t       obs;
    logic [127:0] p;
    nbeats  = 0;
    recon   = '0;
    cyc     = 0;
    fin     = 1'b0;
    rdy_t   = 1'b1;
    stalled = 1'b0;
    held    = '0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL in_ready_idle: got %b want 1", in_ready);
    end
    in_x     = x;
    in_valid = 1'b1;
    push_word(x);
    @(negedge clk);
    n_checks++;
    if (dig_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL first_digit_latency: dig_valid got %b want 1", dig_valid);
    end
    if (poke) begin
      in_x = noise;
    end else begin
      in_valid = 1'b0;
    end
    while (!fin && cyc < 200) begin
      obs = '{dig: dig, idx: dig_idx, last: dig_last};
      n_checks++;
      if (dig_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL conv_flags: dig_valid=%b in_ready=%b want 1/0", dig_valid, in_ready);
      end
      if (stalled) begin
        n_checks++;
        if (obs !== held) begin
          n_fail++;
          $display("FAIL stall_stable: got %h want %h", obs, held);
        end
      end
      if (stall) rdy_t = ~rdy_t;
      dig_ready = stall ? rdy_t : 1'b1;
      if (dig_ready) begin
        stalled = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL queue_underflow: extra beat idx=%0d dig=%0d", dig_idx, dig);
          fin = 1'b1;
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (obs !== e) begin
            n_fail++;
            $display("FAIL beat idx%0d: got dig=%0d idx=%0d last=%b want dig=%0d idx=%0d last=%b",
                     e.idx, obs.dig, obs.idx, obs.last, e.dig, e.idx, e.last);
          end
          p = 128'd1;
          for (int k = 0; k < int'(dig_idx); k++) p = p * 128'd3;
          recon = recon + 128'(dig) * p;
          nbeats++;
          if (e.last) begin
            fin      = 1'b1;
            in_valid = 1'b0;
          end
        end
      end else begin
        stalled = 1'b1;
        held    = obs;
      end
      @(negedge clk);
      cyc++;
    end
    dig_ready = 1'b0;
    in_valid  = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout: word %h did not finish, %0d beats left", x, exp_q.size());
    end
    n_checks++;
    if (in_ready !== 1'b1 || dig_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_last: in_ready=%b dig_valid=%b want 1/0", in_ready, dig_valid);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL beats_missing: %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || dig_valid !== 1'b0 || dig !== 2'd0 || dig_idx !== 6'd0 ||
        dig_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: rdy=%b vld=%b dig=%0d idx=%0d last=%b want 1 0 0 0 0",
               in_ready, dig_valid, dig, dig_idx, dig_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int nb;
    logic [127:0] r;
    run_word(64'd0, 1'b0, 1'b0, 64'd0, nb, r);
`ifndef FIXED_LEN_EN
    n_checks++;
    if (nb != 1) begin
      n_fail++;
      $display("FAIL zero_beats: got %0d want 1", nb);
    end
`endif
  endtask

  task automatic test_five();
    int nb;
    logic [127:0] r;
    run_word(64'd5, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_1234, nb, r);
    n_checks++;
    if (r !== 128'd5) begin
      n_fail++;
      $display("FAIL five_recon: got %0d want 5", r);
    end
  endtask

  task automatic test_hundred_stall();
    int nb;
    logic [127:0] r;
    run_word(64'd100, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, nb, r);
    n_checks++;
    if (r !== 128'd100) begin
      n_fail++;
      $display("FAIL hundred_recon: got %0d want 100", r);
    end
  endtask

  task automatic test_max();
    int nb;
    logic [127:0] r;
    run_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, nb, r);
    n_checks++;
    if (nb != 41 || r !== 128'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL max_word: beats=%0d recon=%h want 41 ffffffffffffffff", nb, r);
    end
  endtask

  task automatic test_reset_midword();
    int nb;
    logic [127:0] r;
    @(negedge clk);
    in_x     = 64'd100;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    dig_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dig_ready = 1'b0;
    n_checks++;
    if (dig_valid !== 1'b1 || dig_idx !== 6'd2) begin
      n_fail++;
      $display("FAIL midword_pos: vld=%b idx=%0d want 1 2", dig_valid, dig_idx);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dig_valid !== 1'b0 || in_ready !== 1'b1 || dig_idx !== 6'd0 || dig !== 2'd0) begin
      n_fail++;
      $display("FAIL async_abort: vld=%b rdy=%b idx=%0d dig=%0d want 0 1 0 0",
               dig_valid, in_ready, dig_idx, dig);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_word(64'd5, 1'b0, 1'b0, 64'd0, nb, r);
    n_checks++;
    if (r !== 128'd5) begin
      n_fail++;
      $display("FAIL after_abort_recon: got %0d want 5", r);
    end
  endtask

  task automatic test_back_to_back();
    int nb;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] x;
      x = {$urandom(), $urandom()} >> (i * 13);
      run_word(x, i[0], 1'b0, 64'd0, nb, r);
      n_checks++;
      if (r !== 128'(x)) begin
        n_fail++;
        $display("FAIL b2b_recon%0d: got %h want %h", i, r, x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_five();
    test_hundred_stall();
    test_max();
    test_reset_midword();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
